mux_scan_n: RTL and testbench

- Parametrised W-bit, N-channel registered multiplexer; successor to the combinational 1-bit 8:1 select mux.
- Two modes:
  - Manual: the select input picks one channel per request.
  - Scan: an internal counter walks channels 0..N-1 and emits one beat per channel.
- Output uses a valid/ready handshake so downstream logic (display, serialiser) can stall.
- Sits between parallel data sources and a single-lane consumer.

---
 rtl/mux_scan_pkg.sv | 7 +
 rtl/mux_n_sel.sv | 20 ++
 rtl/mux_scan_n.sv | 115 +++++++++++
 tb/tb_mux_scan_n.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the mux_scan_n registered channel multiplexer.
package mux_scan_pkg;
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;
endpackage

// File: rtl/mux_n_sel.sv
// Combinational W-bit N:1 channel selector with range flag for non-power-of-2 N.
module mux_n_sel #(
  parameter int W    = 8,
  parameter int N    = 8,
  parameter int SELW = $clog2(N)
) (
  input  logic [N*W-1:0]  in_data,
  input  logic [SELW-1:0] index,
  output logic [W-1:0]    data,
  output logic            in_range
);
  always_comb begin
    data = '0;
    for (int i = 0; i < N; i++)
      if (index == SELW'(i)) data = in_data[i*W +: W];
  end

  // Extra bit keeps the compare exact when N is a power of two.
  assign in_range = ({1'b0, index} < (SELW+1)'(N));
endmodule

// File: rtl/mux_scan_n.sv
// Registered W-bit N-channel mux with manual select and auto-scan modes, valid/ready output.
// Optional even-parity output out_par when MUX_SCAN_PARITY_EN is defined.
module mux_scan_n
  import mux_scan_pkg::*;
#(
  parameter  int W    = 8,
  parameter  int N    = 8,
  localparam int SELW = $clog2(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N*W-1:0]  in_data,
  input  logic            mode,
  input  logic [SELW-1:0] sel,
  input  logic            en,
  input  logic            start,
  output logic [W-1:0]    out_data,
  output logic [SELW-1:0] out_ch,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            busy,
  output logic            done,
  output logic            sel_err
`ifdef MUX_SCAN_PARITY_EN
  ,
  output logic            out_par
`endif
);
  state_t          state, state_nxt;
  logic [SELW-1:0] cnt, cnt_nxt, idx;
  logic [W-1:0]    sel_data;
  logic            in_range, free, load, err_nxt, done_nxt;

  // Manual and scan paths share one selector; cnt drives it only while scanning.
  assign idx  = (state == SCAN) ? cnt : sel;
  assign free = !out_valid || out_ready;
  assign busy = (state != IDLE);

  mux_n_sel #(.W(W), .N(N), .SELW(SELW)) u_sel (
    .in_data (in_data),
    .index   (idx),
    .data    (sel_data),
    .in_range(in_range)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load      = 1'b0;
    err_nxt   = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (mode == MODE_SCAN) begin
          if (start) begin
            state_nxt = SCAN;
            cnt_nxt   = '0;
          end
        end else if (en) begin
          if (!in_range) err_nxt = 1'b1;
          else if (free) load = 1'b1;
        end
      end
      SCAN: begin
        if (free) begin
          load = 1'b1;
          if (cnt == SELW'(N-1)) begin
            state_nxt = DRAIN;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + SELW'(1);
          end
        end
      end
      DRAIN: begin
        if (out_valid && out_ready) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      out_data  <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      sel_err   <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      done    <= done_nxt;
      sel_err <= err_nxt;
      if (load) begin
        out_data  <= sel_data;
        out_ch    <= idx;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef MUX_SCAN_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     out_par <= 1'b0;
    else if (load) out_par <= ^sel_data;
  end
`endif
endmodule

// File: tb/tb_mux_scan_n.sv
// Directed bench for mux_scan_n: one N=8 instance and one N=5 instance on a shared clock/reset.
module tb_mux_scan_n;
  logic clk = 1'b0;
  logic reset;

  logic [63:0] a_in;
  logic        a_mode, a_en, a_start, a_ready;
  logic [2:0]  a_sel;
  logic [7:0]  a_data;
  logic [2:0]  a_ch;
  logic        a_valid, a_busy, a_done, a_err;

  logic [39:0] b_in;
  logic        b_mode, b_en, b_start, b_ready;
  logic [2:0]  b_sel;
  logic [7:0]  b_data;
  logic [2:0]  b_ch;
  logic        b_valid, b_busy, b_done, b_err;

`ifdef MUX_SCAN_PARITY_EN
  logic a_par, b_par;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mux_scan_n #(.W(8), .N(8)) dut_a (
    .clk(clk), .reset(reset), .in_data(a_in), .mode(a_mode), .sel(a_sel),
    .en(a_en), .start(a_start), .out_data(a_data), .out_ch(a_ch),
    .out_valid(a_valid), .out_ready(a_ready), .busy(a_busy), .done(a_done),
    .sel_err(a_err)
`ifdef MUX_SCAN_PARITY_EN
    , .out_par(a_par)
`endif
  );

  mux_scan_n #(.W(8), .N(5)) dut_b (
    .clk(clk), .reset(reset), .in_data(b_in), .mode(b_mode), .sel(b_sel),
    .en(b_en), .start(b_start), .out_data(b_data), .out_ch(b_ch),
    .out_valid(b_valid), .out_ready(b_ready), .busy(b_busy), .done(b_done),
    .sel_err(b_err)
`ifdef MUX_SCAN_PARITY_EN
    , .out_par(b_par)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_beat_a(input string tag, input logic [7:0] d, input logic [2:0] ch);
    check({tag, "_valid"}, a_valid, 1);
    check({tag, "_data"},  a_data,  d);
    check({tag, "_ch"},    a_ch,    ch);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) a_in[i*8 +: 8] = 8'h10 + 8'(i);
    for (int i = 0; i < 5; i++) b_in[i*8 +: 8] = 8'h20 + 8'(i);
    reset = 1'b1;
    a_mode = 1'b0; a_en = 1'b0; a_start = 1'b0; a_ready = 1'b1; a_sel = 3'd0;
    b_mode = 1'b0; b_en = 1'b0; b_start = 1'b0; b_ready = 1'b1; b_sel = 3'd0;

    // Reset state
    #2;
    check("rst_valid", a_valid, 0);
    check("rst_busy",  a_busy,  0);
    check("rst_done",  a_done,  0);
    check("rst_err",   a_err,   0);
    check("rst_data",  a_data,  0);
    check("rst_ch",    a_ch,    0);
`ifdef MUX_SCAN_PARITY_EN
    check("rst_par",   a_par,   0);
`endif
    step(); step();
    reset = 1'b0;

    // Manual select, 1-cycle latency
    a_sel = 3'd5; a_en = 1'b1;
    step();
    check_beat_a("man5", 8'h15, 3'd5);
    check("man5_busy", a_busy, 0);
    a_en = 1'b0;
    step();
    check("man5_unload", a_valid, 0);

    // Manual under stall: second request ignored, beat holds
    a_ready = 1'b0; a_sel = 3'd2; a_en = 1'b1;
    step();
    check_beat_a("man2", 8'h12, 3'd2);
    a_sel = 3'd3;
    step();
    check_beat_a("man2_hold", 8'h12, 3'd2);
    a_en = 1'b0; a_ready = 1'b1;
    step();
    check("man2_unload", a_valid, 0);

    // Scan, no stall
    a_mode = 1'b1; a_start = 1'b1;
    step();
    check("scan_busy", a_busy, 1);
    check("scan_first_lat", a_valid, 0);
    a_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      check_beat_a($sformatf("scan_b%0d", i), 8'h10 + 8'(i), 3'(i));
      check($sformatf("scan_b%0d_done", i), a_done, 0);
    end
    step();
    check("scan_done", a_done, 1);
    check("scan_end_valid", a_valid, 0);
    check("scan_end_busy", a_busy, 0);
    step();
    check("scan_done_pulse", a_done, 0);

    // Scan with backpressure on ch2; start during stall must not restart
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_beat_a($sformatf("bp_b%0d", i), 8'h10 + 8'(i), 3'(i));
    end
    a_ready = 1'b0; a_start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check_beat_a($sformatf("bp_hold%0d", k), 8'h12, 3'd2);
    end
    a_ready = 1'b1; a_start = 1'b0;
    for (int i = 3; i < 8; i++) begin
      step();
      check_beat_a($sformatf("bp_b%0d", i), 8'h10 + 8'(i), 3'(i));
    end
    step();
    check("bp_done", a_done, 1);
    check("bp_end_valid", a_valid, 0);
    step();

    // Reset mid-scan at the 3rd beat
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    step(); step(); step();
    check_beat_a("rs_b2", 8'h12, 3'd2);
    #2 reset = 1'b1;
    #1;
    check("rs_valid", a_valid, 0);
    check("rs_busy",  a_busy,  0);
    check("rs_done",  a_done,  0);
    step();
    reset = 1'b0;
    step();
    check("rs_no_done", a_done, 0);
    check("rs_idle",    a_busy, 0);
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    step();
    check_beat_a("rs_restart_b0", 8'h10, 3'd0);
    for (int i = 1; i < 8; i++) step();
    check_beat_a("rs_restart_b7", 8'h17, 3'd7);
    step();
    check("rs_restart_done", a_done, 1);
    step();

    // N=5: out-of-range select, last in-range select, short scan
    b_sel = 3'd6; b_en = 1'b1;
    step();
    check("n5_err", b_err, 1);
    check("n5_err_noload", b_valid, 0);
    b_en = 1'b0;
    step();
    check("n5_err_pulse", b_err, 0);
    check("n5_err_noload2", b_valid, 0);
    b_sel = 3'd4; b_en = 1'b1;
    step();
    check("n5_sel4_data", b_data, 8'h24);
    check("n5_sel4_ch",   b_ch,   4);
    check("n5_sel4_err",  b_err,  0);
    b_en = 1'b0;
    step();
    b_mode = 1'b1; b_start = 1'b1;
    step();
    b_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("n5_b%0d_valid", i), b_valid, 1);
      check($sformatf("n5_b%0d_data", i),  b_data,  8'h20 + 8'(i));
      check($sformatf("n5_b%0d_ch", i),    b_ch,    i);
    end
    step();
    check("n5_done",  b_done,  1);
    check("n5_no_b5", b_valid, 0);
    step();

`ifdef MUX_SCAN_PARITY_EN
    // Parity of manual loads
    a_mode = 1'b0;
    a_in[7:0] = 8'h07; a_in[15:8] = 8'h03;
    a_sel = 3'd0; a_en = 1'b1;
    step();
    check("par_07_data", a_data, 8'h07);
    check("par_07",      a_par,  1);
    a_sel = 3'd1;
    step();
    check("par_03_data", a_data, 8'h03);
    check("par_03",      a_par,  0);
    a_en = 1'b0;
    step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
